uart_stim_gen: RTL and testbench

//  Parametrised simulation stimulus source for the CPU top.

---
 rtl/uart_stim_gen_pkg.sv | 18 +
 rtl/uart_tx_frame.sv | 103 ++++++++++
 rtl/uart_stim_gen.sv | 136 +++++++++++++
 tb/tb_uart_stim_gen.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_stim_gen_pkg.sv
// Shared types for the UART stimulus generator: sequencer/frame states and frame constants.
package uart_stim_gen_pkg;

    localparam int unsigned UART_BITS = 8;

    typedef enum logic [3:0] {
        WAIT,
        PULSE,
        POST,
        IDLE,
        START,
        DATA,
        STOP,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/uart_tx_frame.sv
// Serialises one byte per load as an 8N1 frame followed by GAP_BITS idle bit times.
module uart_tx_frame
    import uart_stim_gen_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned GAP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [UART_BITS-1:0] data,
    output logic                 rxd,
    output logic                 last
);

    localparam int unsigned TW = $clog2(CLK_PER_BIT) + 1;
    localparam int unsigned BW = $clog2(UART_BITS);
    localparam int unsigned GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(UART_BITS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    state_t               phase_q, phase_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [UART_BITS-1:0] shift_q, shift_d;
    logic                 bit_end;

    assign bit_end = (tmr_q == BIT_LAST);

    // Final clock of the frame; a new load on this clock makes frames back-to-back.
    assign last = bit_end && (((phase_q == STOP) && (GAP_BITS == 0)) ||
                              ((phase_q == GAP) && (gap_q == GAP_LAST)));

    always_comb begin
        phase_d = phase_q;
        tmr_d   = tmr_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        shift_d = shift_q;
        rxd     = 1'b1;
        if (phase_q != IDLE) begin
            tmr_d = bit_end ? '0 : tmr_q + 1'b1;
        end
        case (phase_q)
            START: begin
                rxd = 1'b0;
                if (bit_end) begin
                    phase_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                rxd = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) phase_d = STOP;
                    else                    bit_d   = bit_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (GAP_BITS == 0) begin
                        phase_d = IDLE;
                    end else begin
                        phase_d = GAP;
                        gap_d   = '0;
                    end
                end
            end
            GAP: begin
                if (bit_end) begin
                    if (gap_q == GAP_LAST) phase_d = IDLE;
                    else                   gap_d   = gap_q + 1'b1;
                end
            end
            default: phase_d = IDLE;
        endcase
        if (start && ((phase_q == IDLE) || last)) begin
            phase_d = START;
            shift_d = data;
            tmr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q <= IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            shift_q <= '0;
        end else begin
            phase_q <= phase_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/uart_stim_gen.sv
// Simulation stimulus source: delayed start pulse, then up to DEPTH buffered bytes sent as 8N1 on rxd.
module uart_stim_gen
    import uart_stim_gen_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned START_DELAY = 10,
    parameter int unsigned PULSE_LEN   = 1,
    parameter int unsigned POST_PULSE  = 16,
    parameter int unsigned GAP_BITS    = 1,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned AW          = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic [AW:0]          byte_count,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [UART_BITS-1:0] wr_data,
    output logic                 start_pulse,
    output logic                 rxd,
    output logic                 busy,
    output logic                 done,
    output logic [AW:0]          byte_idx
);

    localparam int unsigned IW = AW + 1;
    localparam logic [IW-1:0] DEPTH_W = IW'(DEPTH);

    logic [UART_BITS-1:0] mem_q [DEPTH];

    state_t               state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [IW-1:0]        n_bytes_q, n_bytes_d;
    logic [IW-1:0]        byte_idx_q, byte_idx_d;
    logic                 tx_start;
    logic                 tx_last;
    logic [UART_BITS-1:0] tx_data;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    // START here means "a frame is in flight"; the bit-level phases live in uart_tx_frame.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_bytes_d  = n_bytes_q;
        byte_idx_d = byte_idx_q;
        tx_start   = 1'b0;
        case (state_q)
            WAIT: begin
                if (cnt_q == 32'(START_DELAY - 1)) begin
                    cnt_d     = '0;
                    state_d   = PULSE;
                    n_bytes_d = (byte_count > DEPTH_W) ? DEPTH_W : byte_count;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == 32'(PULSE_LEN - 1)) begin
                    cnt_d = '0;
                    if (POST_PULSE != 0)      state_d = POST;
                    else if (n_bytes_q == '0) state_d = DONE;
                    else                      state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            POST: begin
                if (cnt_q == 32'(POST_PULSE - 1)) begin
                    cnt_d   = '0;
                    state_d = (n_bytes_q == '0) ? DONE : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (enable) begin
                    tx_start = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                // Chain straight into the next frame so frame spacing has no idle clock.
                if (tx_last) begin
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_d == n_bytes_q) begin
                        state_d = DONE;
                    end else if (enable) begin
                        tx_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: ;
            default: state_d = WAIT;
        endcase
    end

    assign tx_data = mem_q[byte_idx_d[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= WAIT;
            cnt_q      <= '0;
            n_bytes_q  <= '0;
            byte_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_bytes_q  <= n_bytes_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    uart_tx_frame #(
        .CLK_PER_BIT (CLK_PER_BIT),
        .GAP_BITS    (GAP_BITS)
    ) u_tx (
        .clk   (clk),
        .rstn  (rstn),
        .start (tx_start),
        .data  (tx_data),
        .rxd   (rxd),
        .last  (tx_last)
    );

    assign start_pulse = (state_q == PULSE);
    assign busy        = (state_q != WAIT) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign byte_idx    = byte_idx_q;

endmodule

// File: tb/tb_uart_stim_gen.sv
// Directed bench for uart_stim_gen: default timing, frame content/spacing, enable hold, buffer writes, reset.
module tb_uart_stim_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Instance A: default parameters
    logic       rstn_a = 1'b0, enable_a = 1'b0, wr_en_a = 1'b0;
    logic [6:0] bc_a = '0;
    logic [5:0] wa_a = '0;
    logic [7:0] wd_a = '0;
    logic       sp_a, rxd_a, busy_a, done_a;
    logic [6:0] idx_a;

    // Instance B: fast bits, two gap bits
    logic       rstn_b = 1'b0, enable_b = 1'b0, wr_en_b = 1'b0;
    logic [3:0] bc_b = '0;
    logic [2:0] wa_b = '0;
    logic [7:0] wd_b = '0;
    logic       sp_b, rxd_b, busy_b, done_b;
    logic [3:0] idx_b;

    // Instance C: no gap, no post delay, small buffer
    logic       rstn_c = 1'b0, enable_c = 1'b0, wr_en_c = 1'b0;
    logic [2:0] bc_c = '0;
    logic [1:0] wa_c = '0;
    logic [7:0] wd_c = '0;
    logic       sp_c, rxd_c, busy_c, done_c;
    logic [2:0] idx_c;

    uart_stim_gen u_a (
        .clk(clk), .rstn(rstn_a), .enable(enable_a), .byte_count(bc_a),
        .wr_en(wr_en_a), .wr_addr(wa_a), .wr_data(wd_a),
        .start_pulse(sp_a), .rxd(rxd_a), .busy(busy_a), .done(done_a), .byte_idx(idx_a)
    );

    uart_stim_gen #(
        .CLK_PER_BIT(4), .START_DELAY(3), .PULSE_LEN(2), .POST_PULSE(2), .GAP_BITS(2), .DEPTH(8)
    ) u_b (
        .clk(clk), .rstn(rstn_b), .enable(enable_b), .byte_count(bc_b),
        .wr_en(wr_en_b), .wr_addr(wa_b), .wr_data(wd_b),
        .start_pulse(sp_b), .rxd(rxd_b), .busy(busy_b), .done(done_b), .byte_idx(idx_b)
    );

    uart_stim_gen #(
        .CLK_PER_BIT(3), .START_DELAY(1), .PULSE_LEN(1), .POST_PULSE(0), .GAP_BITS(0), .DEPTH(4)
    ) u_c (
        .clk(clk), .rstn(rstn_c), .enable(enable_c), .byte_count(bc_c),
        .wr_en(wr_en_c), .wr_addr(wa_c), .wr_data(wd_c),
        .start_pulse(sp_c), .rxd(rxd_c), .busy(busy_c), .done(done_c), .byte_idx(idx_c)
    );

    typedef struct {
        int         cyc;
        logic       sp;
        logic       bz;
        logic       dn;
        logic       rx;
        logic [6:0] idx;
    } vec_t;

    vec_t       tbl [7];
    logic [7:0] data_b [4] = '{8'hA5, 8'h3C, 8'hC3, 8'h5A};
    logic [7:0] data_c [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    function automatic logic sel_rxd(input int w);
        return (w == 0) ? rxd_b : rxd_c;
    endfunction

    task automatic wait_fall(input int w, input int budget, output int t);
        bit ok;
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (sel_rxd(w) == 1'b0) begin
                ok = 1'b1;
                t  = int'(cyc);
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_fall: no start bit within %0d clocks", budget);
        end
    endtask

    // Called right after a start-bit fall is seen; samples each bit one clock into its window.
    task automatic capture(input int w, input int cpb, input int drop_bit, input int wr_bit,
                           output logic [9:0] cap);
        @(posedge clk); #1;
        cap[0] = sel_rxd(w);
        for (int j = 1; j < 10; j++) begin
            repeat (cpb) @(posedge clk);
            #1;
            cap[j] = sel_rxd(w);
            if (w == 0) begin
                if (j == drop_bit) enable_b = 1'b0;
                if (j == wr_bit) begin
                    wr_en_b = 1'b1;
                    wa_b    = 3'd1;
                    wd_b    = 8'h99;
                end else begin
                    wr_en_b = 1'b0;
                end
            end
        end
    endtask

    task automatic restart_b(input logic [3:0] count);
        @(negedge clk);
        rstn_b   = 1'b0;
        bc_b     = count;
        enable_b = 1'b1;
        @(negedge clk);
        rstn_b = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] cap;
        int         t1, t2, t3, tp, lows, k;

        tbl[0] = '{0,  1'b0, 1'b0, 1'b0, 1'b1, 7'd0};
        tbl[1] = '{9,  1'b0, 1'b0, 1'b0, 1'b1, 7'd0};
        tbl[2] = '{10, 1'b1, 1'b1, 1'b0, 1'b1, 7'd0};
        tbl[3] = '{11, 1'b0, 1'b1, 1'b0, 1'b1, 7'd0};
        tbl[4] = '{26, 1'b0, 1'b1, 1'b0, 1'b1, 7'd0};
        tbl[5] = '{27, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0};
        tbl[6] = '{40, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0};

        // Preload buffers while the instances are held in reset
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_en_b = 1'b1; wa_b = 3'(i); wd_b = data_b[i];
            wr_en_c = 1'b1; wa_c = 2'(i); wd_c = data_c[i];
        end
        @(negedge clk);
        wr_en_b = 1'b0;
        wr_en_c = 1'b0;

        // Defaults with byte_count=0: pulse in cycle 10 only, done at cycle 27, rxd never low
        bc_a     = '0;
        enable_a = 1'b1;
        @(negedge clk);
        rstn_a = 1'b1;
        lows   = 0;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end else begin
                #1;
            end
            if (rxd_a == 1'b0) lows++;
            for (int i = 0; i < 7; i++) begin
                if (tbl[i].cyc == c) begin
                    chk($sformatf("a_start_pulse@%0d", c), sp_a,   tbl[i].sp);
                    chk($sformatf("a_busy@%0d", c),        busy_a, tbl[i].bz);
                    chk($sformatf("a_done@%0d", c),        done_a, tbl[i].dn);
                    chk($sformatf("a_rxd@%0d", c),         rxd_a,  tbl[i].rx);
                    chk($sformatf("a_byte_idx@%0d", c),    idx_a,  tbl[i].idx);
                end
            end
        end
        chk("a_rxd_never_low", lows, 0);

        // Three frames with GAP_BITS=2: content and 12-bit spacing
        restart_b(4'd3);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            chk($sformatf("b_start_pulse@%0d", c), sp_b, (c >= 3 && c < 5));
        end
        wait_fall(0, 50, t1);
        capture(0, 4, -1, -1, cap);
        chk("b_frame0_a5", cap, 10'h34A);
        wait_fall(0, 50, t2);
        chk("b_spacing_01", t2 - t1, 48);
        capture(0, 4, -1, -1, cap);
        chk("b_frame1", cap, frame_of(data_b[1]));
        wait_fall(0, 50, t3);
        chk("b_spacing_12", t3 - t2, 48);
        capture(0, 4, -1, -1, cap);
        chk("b_frame2", cap, frame_of(data_b[2]));
        repeat (15) @(posedge clk);
        #1;
        chk("b_done", done_b, 1'b1);
        chk("b_busy_after_done", busy_b, 1'b0);
        chk("b_byte_idx_done", idx_b, 4'd3);
        chk("b_rxd_idle_done", rxd_b, 1'b1);

        // Drop enable mid-DATA of frame 2 and overwrite its buffer entry in flight
        restart_b(4'd3);
        wait_fall(0, 50, t1);
        capture(0, 4, -1, -1, cap);
        chk("hold_frame0", cap, frame_of(data_b[0]));
        wait_fall(0, 50, t2);
        capture(0, 4, 3, 5, cap);
        wr_en_b = 1'b0;
        chk("hold_frame1_old_byte", cap, frame_of(data_b[1]));
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (rxd_b == 1'b0) lows++;
        end
        chk("hold_rxd_high", lows, 0);
        chk("hold_byte_idx", idx_b, 4'd2);
        chk("hold_busy", busy_b, 1'b1);
        chk("hold_not_done", done_b, 1'b0);
        enable_b = 1'b1;
        wait_fall(0, 50, t3);
        capture(0, 4, -1, -1, cap);
        chk("resume_frame2", cap, frame_of(data_b[2]));
        repeat (15) @(posedge clk);
        #1;
        chk("resume_done", done_b, 1'b1);

        // New value written during the previous run is sent intact
        restart_b(4'd2);
        wait_fall(0, 50, t1);
        capture(0, 4, -1, -1, cap);
        chk("rewrite_frame0", cap, frame_of(data_b[0]));
        wait_fall(0, 50, t2);
        capture(0, 4, -1, -1, cap);
        chk("rewrite_frame1_new", cap, frame_of(8'h99));

        // Asynchronous reset during a low data bit, then restart timing
        restart_b(4'd3);
        wait_fall(0, 50, t1);
        repeat (9) @(posedge clk);
        #1;
        chk("rst_pre_rxd_low", rxd_b, 1'b0);
        chk("rst_pre_busy", busy_b, 1'b1);
        rstn_b = 1'b0;
        #1;
        chk("rst_rxd", rxd_b, 1'b1);
        chk("rst_busy", busy_b, 1'b0);
        chk("rst_start_pulse", sp_b, 1'b0);
        chk("rst_done", done_b, 1'b0);
        chk("rst_byte_idx", idx_b, 4'd0);
        @(negedge clk);
        rstn_b = 1'b1;
        k = 11;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (sp_b) begin
                k = c;
                break;
            end
        end
        chk("rst_restart_delay", k, 3);

        // byte_count above DEPTH is clamped; GAP_BITS=0 gives 10-bit spacing
        bc_c     = 3'd7;
        enable_c = 1'b1;
        @(negedge clk);
        rstn_c = 1'b1;
        tp = 0;
        for (int f = 0; f < 4; f++) begin
            wait_fall(1, 60, t1);
            if (f > 0) chk($sformatf("c_spacing_%0d", f), t1 - tp, 30);
            tp = t1;
            capture(1, 3, -1, -1, cap);
            chk($sformatf("c_frame%0d", f), cap, frame_of(data_c[f]));
        end
        lows = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rxd_c == 1'b0) lows++;
        end
        chk("c_no_fifth_frame", lows, 0);
        chk("c_done", done_c, 1'b1);
        chk("c_byte_idx_clamped", idx_c, 3'd4);
        chk("c_busy_after_done", busy_c, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
